bound_flasher_param: RTL and testbench

Parametrised bound-flasher lamp sequencer: a flick request starts a thermometer-coded lamp bar that fills and drains through three bounded rounds, with flick kickback at intermediate bounds. It generalises the fixed 16-lamp flasher to any lamp count, configurable bounds and a step-rate prescaler, and adds reset, busy and phase status outputs. It sits directly behind the board's flick button synchroniser and drives the LED bank.

---
 rtl/bound_flasher_param.sv | 158 +++++++++++++++
 tb/tb_bound_flasher_param.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_param.sv
// Parametrised bound-flasher lamp sequencer: thermometer bar fills/drains over three bounded rounds.
// Optional BOUND_FLASHER_PARAM_LOOP_EN restarts the sequence after DN3 instead of idling.
module bound_flasher_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned B1       = 6,
   parameter int unsigned B2       = 11,
   parameter int unsigned STEP_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flick,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic [2:0]       phase
);

   localparam int unsigned NW = $clog2(WIDTH + 1);
   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] UP1  = 3'd1;
   localparam logic [2:0] DN1  = 3'd2;
   localparam logic [2:0] UP2  = 3'd3;
   localparam logic [2:0] DN2  = 3'd4;
   localparam logic [2:0] UP3  = 3'd5;
   localparam logic [2:0] DN3  = 3'd6;

   localparam logic [NW-1:0] N_ZERO  = '0;
   localparam logic [NW-1:0] N_ONE   = NW'(1);
   localparam logic [NW-1:0] N_B1    = NW'(B1);
   localparam logic [NW-1:0] N_B2    = NW'(B2);
   localparam logic [NW-1:0] N_TOP   = NW'(WIDTH);
   localparam logic [CW-1:0] CNT_END = CW'(STEP_DIV - 1);

   logic [2:0]       phase_q, phase_d;
   logic [NW-1:0]    n_q, n_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q;
   logic             busy_q;
   logic             step;

   function automatic logic [WIDTH-1:0] therm(input logic [NW-1:0] lit);
      logic [WIDTH-1:0] bar;
      bar = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         bar[i] = (i < int'(lit));
      end
      return bar;
   endfunction

   assign step = (cnt_q == CNT_END);

   always_comb begin
      phase_d = phase_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      if (phase_q == IDLE) begin
         cnt_d = '0;
         n_d   = N_ZERO;
         if (flick) begin
            phase_d = UP1;
            n_d     = N_ONE;
         end
      end else begin
         cnt_d = step ? '0 : cnt_q + CW'(1);
         // n and phase only move on step cycles; kickback flick is sampled here too.
         if (step) begin
            case (phase_q)
               UP1: begin
                  if (n_q == N_B1) begin
                     phase_d = DN1;
                     n_d     = N_B1 - N_ONE;
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end
               DN1: begin
                  if (n_q == N_ZERO) begin
                     phase_d = UP2;
                     n_d     = N_ONE;
                  end else begin
                     n_d = n_q - N_ONE;
                  end
               end
               UP2: begin
                  if (n_q == N_B1 && flick) begin
                     phase_d = DN1;
                     n_d     = N_B1 - N_ONE;
                  end else if (n_q == N_B2) begin
                     phase_d = DN2;
                     n_d     = N_B2 - N_ONE;
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end
               DN2: begin
                  if (n_q == N_B1) begin
                     phase_d = UP3;
                     n_d     = N_B1 + N_ONE;
                  end else begin
                     n_d = n_q - N_ONE;
                  end
               end
               UP3: begin
                  if (n_q == N_B2 && flick) begin
                     phase_d = DN2;
                     n_d     = N_B2 - N_ONE;
                  end else if (n_q == N_TOP) begin
                     phase_d = DN3;
                     n_d     = N_TOP - N_ONE;
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end
               DN3: begin
                  if (n_q == N_ZERO) begin
`ifdef BOUND_FLASHER_PARAM_LOOP_EN
                     phase_d = UP1;
                     n_d     = N_ONE;
`else
                     phase_d = IDLE;
                     n_d     = N_ZERO;
`endif
                  end else begin
                     n_d = n_q - N_ONE;
                  end
               end
               default: begin
                  phase_d = IDLE;
                  n_d     = N_ZERO;
               end
            endcase
         end
      end
   end

   // Outputs are decoded from next-state so they stay registered yet cycle-aligned with n.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= IDLE;
         n_q     <= N_ZERO;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         out_q   <= therm(n_d);
         busy_q  <= (phase_d != IDLE);
      end
   end

   assign out   = out_q;
   assign busy  = busy_q;
   assign phase = phase_q;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Directed bench for bound_flasher_param: default 16-lamp instance plus an 8-lamp STEP_DIV=3 one.
module tb_bound_flasher_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flick;
   logic [15:0] out;
   logic        busy;
   logic [2:0]  phase;

   logic        rst8, flick8;
   logic [7:0]  out8;
   logic        busy8;
   logic [2:0]  phase8;

   int vectors = 0;
   int errors  = 0;

   int         nom_n[54];
   logic [2:0] nom_p[54];
   int         qn[$];
   logic [2:0] qp[$];

`ifdef BOUND_FLASHER_PARAM_LOOP_EN
   localparam logic [15:0] END_OUT   = 16'h0001;
   localparam logic        END_BUSY  = 1'b1;
   localparam logic [2:0]  END_PHASE = 3'd1;
   localparam logic [15:0] END2_OUT  = 16'h0003;
   localparam logic [7:0]  END8_OUT  = 8'h01;
`else
   localparam logic [15:0] END_OUT   = 16'h0000;
   localparam logic        END_BUSY  = 1'b0;
   localparam logic [2:0]  END_PHASE = 3'd0;
   localparam logic [15:0] END2_OUT  = 16'h0001;
   localparam logic [7:0]  END8_OUT  = 8'h00;
`endif

   bound_flasher_param u_dut (
      .clk   (clk),
      .rst   (rst),
      .flick (flick),
      .out   (out),
      .busy  (busy),
      .phase (phase)
   );

   bound_flasher_param #(
      .WIDTH    (8),
      .B1       (2),
      .B2       (5),
      .STEP_DIV (3)
   ) u_dut8 (
      .clk   (clk),
      .rst   (rst8),
      .flick (flick8),
      .out   (out8),
      .busy  (busy8),
      .phase (phase8)
   );

   function automatic logic [15:0] th16(input int n);
      logic [31:0] t;
      t = (32'h1 << n) - 32'h1;
      return t[15:0];
   endfunction

   function automatic logic [7:0] th8(input int n);
      logic [31:0] t;
      t = (32'h1 << n) - 32'h1;
      return t[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset16();
      rst = 1'b1;
      flick = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic start16();
      flick = 1'b1;
      tick();
      flick = 1'b0;
   endtask

   task automatic build_tables();
      int k;
      k = 0;
      for (int v = 1; v <= 6; v++) begin nom_n[k] = v; nom_p[k] = 3'd1; k++; end
      for (int v = 5; v >= 0; v--) begin nom_n[k] = v; nom_p[k] = 3'd2; k++; end
      for (int v = 1; v <= 11; v++) begin nom_n[k] = v; nom_p[k] = 3'd3; k++; end
      for (int v = 10; v >= 6; v--) begin nom_n[k] = v; nom_p[k] = 3'd4; k++; end
      for (int v = 7; v <= 16; v++) begin nom_n[k] = v; nom_p[k] = 3'd5; k++; end
      for (int v = 15; v >= 0; v--) begin nom_n[k] = v; nom_p[k] = 3'd6; k++; end
   endtask

   task automatic test_reset();
      rst = 1'b1; flick = 1'b1; rst8 = 1'b1; flick8 = 1'b1;
      tick();
      tick();
      vectors++;
      if ({out, busy, phase} !== {16'h0000, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset16: got out=%h busy=%b phase=%0d, want 0000/0/0", out, busy, phase);
      end
      vectors++;
      if ({out8, busy8, phase8} !== {8'h00, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset8: got out=%h busy=%b phase=%0d, want 00/0/0", out8, busy8, phase8);
      end
      rst = 1'b0; flick = 1'b0; rst8 = 1'b0; flick8 = 1'b0;
      tick();
      tick();
      vectors++;
      if ({out, busy, phase} !== {16'h0000, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL idle_no_flick: got out=%h busy=%b phase=%0d, want 0000/0/0",
                  out, busy, phase);
      end
   endtask

   task automatic test_nominal();
      reset16();
      start16();
      for (int i = 0; i < 54; i++) begin
         if (i > 0) tick();
         vectors++;
         if ({out, busy, phase} !== {th16(nom_n[i]), 1'b1, nom_p[i]}) begin
            errors++;
            $display("FAIL nominal[%0d]: got out=%h busy=%b phase=%0d, want out=%h busy=1 phase=%0d",
                     i, out, busy, phase, th16(nom_n[i]), nom_p[i]);
         end
      end
      tick();
      vectors++;
      if ({out, busy, phase} !== {END_OUT, END_BUSY, END_PHASE}) begin
         errors++;
         $display("FAIL nominal_end: got out=%h busy=%b phase=%0d, want out=%h busy=%b phase=%0d",
                  out, busy, phase, END_OUT, END_BUSY, END_PHASE);
      end
   endtask

   task automatic test_back_to_back();
      reset16();
      start16();
      repeat (53) tick();
      vectors++;
      if ({out, phase} !== {16'h0000, 3'd6}) begin
         errors++;
         $display("FAIL b2b_last: got out=%h phase=%0d, want 0000/6", out, phase);
      end
      flick = 1'b1;
      tick();
      vectors++;
      if ({out, busy, phase} !== {END_OUT, END_BUSY, END_PHASE}) begin
         errors++;
         $display("FAIL b2b_end_edge: got out=%h busy=%b phase=%0d, want out=%h busy=%b phase=%0d",
                  out, busy, phase, END_OUT, END_BUSY, END_PHASE);
      end
      tick();
      flick = 1'b0;
      vectors++;
      if ({out, busy, phase} !== {END2_OUT, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL b2b_restart: got out=%h busy=%b phase=%0d, want out=%h busy=1 phase=1",
                  out, busy, phase, END2_OUT);
      end
   endtask

   task automatic test_kick_b1();
      reset16();
      start16();
      repeat (12) tick();
      vectors++;
      if ({out, phase} !== {16'h0001, 3'd3}) begin
         errors++;
         $display("FAIL kb1_entry: got out=%h phase=%0d, want 0001/3", out, phase);
      end
      flick = 1'b1;
      qn.delete(); qp.delete();
      for (int v = 2; v <= 6; v++) begin qn.push_back(v); qp.push_back(3'd3); end
      for (int v = 5; v >= 0; v--) begin qn.push_back(v); qp.push_back(3'd2); end
      for (int v = 1; v <= 6; v++) begin qn.push_back(v); qp.push_back(3'd3); end
      qn.push_back(5); qp.push_back(3'd2);
      for (int i = 0; i < qn.size(); i++) begin
         tick();
         vectors++;
         if ({out, phase} !== {th16(qn[i]), qp[i]}) begin
            errors++;
            $display("FAIL kb1_held[%0d]: got out=%h phase=%0d, want out=%h phase=%0d",
                     i, out, phase, th16(qn[i]), qp[i]);
         end
      end
      flick = 1'b0;
      qn.delete(); qp.delete();
      for (int v = 4; v >= 0; v--) begin qn.push_back(v); qp.push_back(3'd2); end
      for (int v = 1; v <= 11; v++) begin qn.push_back(v); qp.push_back(3'd3); end
      qn.push_back(10); qp.push_back(3'd4);
      for (int i = 0; i < qn.size(); i++) begin
         tick();
         vectors++;
         if ({out, phase} !== {th16(qn[i]), qp[i]}) begin
            errors++;
            $display("FAIL kb1_release[%0d]: got out=%h phase=%0d, want out=%h phase=%0d",
                     i, out, phase, th16(qn[i]), qp[i]);
         end
      end
   endtask

   task automatic test_kick_b2();
      reset16();
      start16();
      repeat (32) tick();
      vectors++;
      if ({out, phase} !== {16'h07FF, 3'd5}) begin
         errors++;
         $display("FAIL kb2_entry: got out=%h phase=%0d, want 07FF/5", out, phase);
      end
      flick = 1'b1;
      tick();
      flick = 1'b0;
      vectors++;
      if ({out, busy, phase} !== {16'h03FF, 1'b1, 3'd4}) begin
         errors++;
         $display("FAIL kb2_kick: got out=%h busy=%b phase=%0d, want 03FF/1/4", out, busy, phase);
      end
      qn.delete(); qp.delete();
      for (int v = 9; v >= 6; v--) begin qn.push_back(v); qp.push_back(3'd4); end
      for (int v = 7; v <= 12; v++) begin qn.push_back(v); qp.push_back(3'd5); end
      for (int i = 0; i < qn.size(); i++) begin
         tick();
         vectors++;
         if ({out, phase} !== {th16(qn[i]), qp[i]}) begin
            errors++;
            $display("FAIL kb2_after[%0d]: got out=%h phase=%0d, want out=%h phase=%0d",
                     i, out, phase, th16(qn[i]), qp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset16();
      start16();
      repeat (25) tick();
      vectors++;
      if ({out, phase} !== {16'h00FF, 3'd4}) begin
         errors++;
         $display("FAIL rstmid_entry: got out=%h phase=%0d, want 00FF/4", out, phase);
      end
      rst = 1'b1;
      flick = 1'b1;
      tick();
      vectors++;
      if ({out, busy, phase} !== {16'h0000, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL rstmid_reset: got out=%h busy=%b phase=%0d, want 0000/0/0", out, busy, phase);
      end
      rst = 1'b0;
      flick = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({out, busy, phase} !== {16'h0000, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL rstmid_hold: got out=%h busy=%b phase=%0d, want 0000/0/0", out, busy, phase);
      end
      start16();
      vectors++;
      if ({out, busy, phase} !== {16'h0001, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL rstmid_restart: got out=%h busy=%b phase=%0d, want 0001/1/1",
                  out, busy, phase);
      end
   endtask

   task automatic test_step_div();
      rst8 = 1'b1;
      flick8 = 1'b0;
      tick();
      rst8 = 1'b0;
      qn.delete();
      qn.push_back(1); qn.push_back(2); qn.push_back(1); qn.push_back(0);
      for (int v = 1; v <= 5; v++) qn.push_back(v);
      for (int v = 4; v >= 2; v--) qn.push_back(v);
      for (int v = 3; v <= 8; v++) qn.push_back(v);
      for (int v = 7; v >= 0; v--) qn.push_back(v);
      flick8 = 1'b1;
      tick();
      flick8 = 1'b0;
      for (int i = 0; i < qn.size(); i++) begin
         if (i > 0) begin
            repeat (2) begin
               tick();
               vectors++;
               if ({out8, busy8} !== {th8(qn[i-1]), 1'b1}) begin
                  errors++;
                  $display("FAIL div_hold[%0d]: got out=%h busy=%b, want out=%h busy=1",
                           i, out8, busy8, th8(qn[i-1]));
               end
            end
            tick();
         end
         vectors++;
         if ({out8, busy8} !== {th8(qn[i]), 1'b1}) begin
            errors++;
            $display("FAIL div_step[%0d]: got out=%h busy=%b, want out=%h busy=1",
                     i, out8, busy8, th8(qn[i]));
         end
      end
      repeat (2) tick();
      vectors++;
      if ({out8, busy8, phase8} !== {8'h00, 1'b1, 3'd6}) begin
         errors++;
         $display("FAIL div_last_hold: got out=%h busy=%b phase=%0d, want 00/1/6",
                  out8, busy8, phase8);
      end
      tick();
      vectors++;
      if ({out8, busy8, phase8} !== {END8_OUT, END_BUSY, END_PHASE}) begin
         errors++;
         $display("FAIL div_end: got out=%h busy=%b phase=%0d, want out=%h busy=%b phase=%0d",
                  out8, busy8, phase8, END8_OUT, END_BUSY, END_PHASE);
      end
   endtask

   initial begin
      rst = 1'b1; flick = 1'b0; rst8 = 1'b1; flick8 = 1'b0;
      build_tables();
      test_reset();
      test_nominal();
      test_back_to_back();
      test_kick_b1();
      test_kick_b2();
      test_reset_mid();
      test_step_div();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
